// File: rtl/check4_pkg.sv
// rtl/check4_pkg.sv - shared types, constants and compare helpers for check4
//
// Purpose : pixel/coordinate types, window geometry, default frame size and
//           threshold, candidate marker, and the per-compass classify helper.
// Ports   : none (package).
// Config  : CHECK4_STRICT_EN is consumed in check4.sv, not here.
package check4_pkg;

  typedef logic [7:0] pixel_t;
  typedef logic [9:0] coord_t;

  localparam int RADIUS        = 3;
  localparam int DEF_WIDTH     = 800;
  localparam int DEF_HEIGHT    = 600;
  localparam int DEF_THRESHOLD = 20;

  localparam pixel_t CAND_MARK = 8'hFF;

  // The four radius-3 compass samples around one centre pixel.
  typedef struct packed {
    pixel_t n;
    pixel_t s;
    pixel_t w;
    pixel_t e;
  } compass_t;

  // Returns {brighter, darker} for one compass sample. Widening to 9 bits
  // keeps c+th and p+th from wrapping near white or black.
  function automatic logic [1:0] classify(pixel_t p, pixel_t c, pixel_t th);
    logic [8:0] p9;
    logic [8:0] c9;
    logic [8:0] t9;
    p9 = {1'b0, p};
    c9 = {1'b0, c};
    t9 = {1'b0, th};
    return {(p9 >= c9 + t9), (p9 + t9 <= c9)};
  endfunction

  function automatic logic [2:0] popcount4(logic [3:0] v);
    return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

endpackage

// File: rtl/check4_if.sv
// rtl/check4_if.sv - pixel-in / result-out bundle for check4
//
// Purpose : groups the input pixel stream and the tagged result stream.
// Signals : din/valid       raster pixel in, no backpressure
//           dout/validout   result pixel (0xFF for a candidate, else centre)
//           rowcount/colcount  centre coordinate of the result
// Modports: master = pixel source / result sink, slave = check4.
interface check4_if;
  import check4_pkg::*;

  pixel_t din;
  logic   valid;
  pixel_t dout;
  logic   validout;
  coord_t rowcount;
  coord_t colcount;

  modport master (
    output din, valid,
    input  dout, validout, rowcount, colcount
  );

  modport slave (
    input  din, valid,
    output dout, validout, rowcount, colcount
  );

endinterface

// File: rtl/check4_line_buffer.sv
// rtl/check4_line_buffer.sv - one-line pixel delay for the check4 window
//
// Purpose : WIDTH-deep x 8 delay line. dout_o is the pixel accepted exactly
//           WIDTH accepted pixels ago; the slot is read and overwritten on
//           the same accepted pixel, so one port suffices.
// Ports   : clock, reset (sync, active-high, clears the pointer only)
//           valid_i  advance the line
//           din_i    pixel to store
//           dout_o   pixel from one line earlier (same column)
module check4_line_buffer
  import check4_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic   clock,
  input  logic   reset,
  input  logic   valid_i,
  input  pixel_t din_i,
  output pixel_t dout_o
);

  localparam int AW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [AW-1:0] PTR_LAST = AW'(WIDTH - 1);

  pixel_t        mem_q [0:WIDTH-1];
  logic [AW-1:0] ptr_q;
  logic [AW-1:0] ptr_d;

  assign dout_o = mem_q[ptr_q];

  always_comb begin
    ptr_d = ptr_q;
    if (valid_i) begin
      ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + AW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Contents are never reset; downstream position gating hides stale lines.
  always_ff @(posedge clock) begin
    if (valid_i) begin
      mem_q[ptr_q] <= din_i;
    end
  end

endmodule

// File: rtl/check4.sv
// rtl/check4.sv - streaming FAST-style 4-point corner pre-test
//
// Purpose : compares each interior pixel with its N/S/W/E neighbours at
//           radius 3 and emits 0xFF for a corner candidate, else the centre
//           value, tagged with the centre row/column. Latency 2 cycles,
//           1 pixel/cycle, no backpressure.
// Ports   : clock   sole clock, rising edge
//           reset   synchronous, active-high
//           pix     check4_if.slave (din/valid in, dout/validout/rowcount/
//                   colcount out)
// Config  : CHECK4_STRICT_EN defined -> all 4 compass pixels must agree;
//           undefined (default) -> 3 of 4 is enough.
module check4
  import check4_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int HEIGHT    = DEF_HEIGHT,
  parameter int THRESHOLD = DEF_THRESHOLD
) (
  input  logic     clock,
  input  logic     reset,
  check4_if.slave  pix
);

  localparam int     DIAM     = 2 * RADIUS;
  localparam coord_t COL_LAST = coord_t'(WIDTH - 1);
  localparam coord_t ROW_LAST = coord_t'(HEIGHT - 1);
  localparam coord_t EDGE     = coord_t'(DIAM);
  localparam coord_t RAD_C    = coord_t'(RADIUS);
  localparam pixel_t THR      = pixel_t'(THRESHOLD);

  // ---------------------------------------------------------------------
  // Stage 0: input position counters and registered input pixel.
  // ---------------------------------------------------------------------
  coord_t in_col_q, in_col_d;
  coord_t in_row_q, in_row_d;
  pixel_t px_q;
  logic   pv_q;
  coord_t prow_q, pcol_q;

  always_comb begin
    in_col_d = in_col_q;
    in_row_d = in_row_q;
    if (pix.valid) begin
      if (in_col_q == COL_LAST) begin
        in_col_d = '0;
        in_row_d = (in_row_q == ROW_LAST) ? '0 : in_row_q + coord_t'(1);
      end else begin
        in_col_d = in_col_q + coord_t'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      in_col_q <= '0;
      in_row_q <= '0;
      px_q     <= '0;
      pv_q     <= 1'b0;
      prow_q   <= '0;
      pcol_q   <= '0;
    end else begin
      in_col_q <= in_col_d;
      in_row_q <= in_row_d;
      px_q     <= pix.din;
      pv_q     <= pix.valid;
      prow_q   <= in_row_q;
      pcol_q   <= in_col_q;
    end
  end

  // ---------------------------------------------------------------------
  // Stage 1: six chained line buffers give a vertical column of 7 pixels
  // (tap[k] = row r-k at column c); three row shift registers keep only
  // the columns the compass test reads.
  // ---------------------------------------------------------------------
  pixel_t tap [0:DIAM];

  assign tap[0] = px_q;

  for (genvar i = 0; i < DIAM; i++) begin : g_lb
    check4_line_buffer #(
      .WIDTH (WIDTH)
    ) u_lb (
      .clock   (clock),
      .reset   (reset),
      .valid_i (pv_q),
      .din_i   (tap[i]),
      .dout_o  (tap[i+1])
    );
  end

  // rX_q[j] holds row r-X at column c-j after the shift for column c.
  pixel_t r0_q [0:RADIUS];
  pixel_t r3_q [0:DIAM];
  pixel_t r6_q [0:RADIUS];
  logic   wv_q;
  coord_t wrow_q, wcol_q;

  always_ff @(posedge clock) begin
    if (pv_q) begin
      r0_q[0] <= tap[0];
      r3_q[0] <= tap[RADIUS];
      r6_q[0] <= tap[DIAM];
      for (int j = 1; j <= RADIUS; j++) begin
        r0_q[j] <= r0_q[j-1];
        r6_q[j] <= r6_q[j-1];
      end
      for (int j = 1; j <= DIAM; j++) begin
        r3_q[j] <= r3_q[j-1];
      end
    end
  end

  // A result exists only once a full 7x7 neighbourhood has been seen.
  always_ff @(posedge clock) begin
    if (reset) begin
      wv_q   <= 1'b0;
      wrow_q <= '0;
      wcol_q <= '0;
    end else begin
      wv_q <= pv_q && (prow_q >= EDGE) && (pcol_q >= EDGE);
      if (pv_q) begin
        wrow_q <= prow_q - RAD_C;
        wcol_q <= pcol_q - RAD_C;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stage 2: compass compare and output register.
  // ---------------------------------------------------------------------
  compass_t   cmp;
  pixel_t     ctr;
  logic [3:0] bright;
  logic [3:0] dark;
  logic [2:0] n_bright;
  logic [2:0] n_dark;
  logic       cand;
  pixel_t     dout_d;

  always_comb begin
    ctr   = r3_q[RADIUS];
    cmp.n = r6_q[RADIUS];
    cmp.s = r0_q[RADIUS];
    cmp.w = r3_q[DIAM];
    cmp.e = r3_q[0];
    {bright[3], dark[3]} = classify(cmp.n, ctr, THR);
    {bright[2], dark[2]} = classify(cmp.s, ctr, THR);
    {bright[1], dark[1]} = classify(cmp.w, ctr, THR);
    {bright[0], dark[0]} = classify(cmp.e, ctr, THR);
    n_bright = popcount4(bright);
    n_dark   = popcount4(dark);
`ifdef CHECK4_STRICT_EN
    cand = (n_bright == 3'd4) || (n_dark == 3'd4);
`else
    cand = (n_bright >= 3'd3) || (n_dark >= 3'd3);
`endif
    dout_d = cand ? CAND_MARK : ctr;
  end

  pixel_t dout_q;
  logic   validout_q;
  coord_t rowcount_q, colcount_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      dout_q     <= '0;
      validout_q <= 1'b0;
      rowcount_q <= '0;
      colcount_q <= '0;
    end else begin
      validout_q <= wv_q;
      if (wv_q) begin
        dout_q     <= dout_d;
        rowcount_q <= wrow_q;
        colcount_q <= wcol_q;
      end
    end
  end

  assign pix.dout     = dout_q;
  assign pix.validout = validout_q;
  assign pix.rowcount = rowcount_q;
  assign pix.colcount = colcount_q;

endmodule

// File: tb/tb_check4.sv
// tb/tb_check4.sv - self-checking bench for check4 on a reduced 16x12 frame
module tb_check4;
  import check4_pkg::*;

  localparam int TW = 16;
  localparam int TH = 12;
  localparam int NPIX = TW * TH;
  localparam int EXP_PULSES = (TH - 6) * (TW - 6);
`ifdef CHECK4_STRICT_EN
  localparam logic [7:0] EXP_THREE = 8'h50;
`else
  localparam logic [7:0] EXP_THREE = 8'hFF;
`endif

  logic clock = 1'b0;
  logic reset;

  check4_if pix ();

  check4 #(
    .WIDTH     (TW),
    .HEIGHT    (TH),
    .THRESHOLD (20)
  ) dut (
    .clock (clock),
    .reset (reset),
    .pix   (pix)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- result monitor ----------------
  logic [7:0] out_img [0:TH-1][0:TW-1];
  int seen [0:TH-1][0:TW-1];
  int pulses, oob, first_cyc, first_row, first_col, last_row, last_col;
  bit got_first;
  int frame_tag = 0;
  int mon_tag = 0;

  always @(negedge clock) begin
    if (frame_tag != mon_tag) begin
      mon_tag = frame_tag;
      pulses = 0;
      oob = 0;
      got_first = 1'b0;
      for (int r = 0; r < TH; r++)
        for (int c = 0; c < TW; c++) begin
          seen[r][c] = 0;
          out_img[r][c] = 8'h00;
        end
    end
    if (pix.validout === 1'b1) begin
      pulses++;
      if (!got_first) begin
        got_first = 1'b1;
        first_cyc = cyc;
        first_row = int'(pix.rowcount);
        first_col = int'(pix.colcount);
      end
      last_row = int'(pix.rowcount);
      last_col = int'(pix.colcount);
      if (pix.rowcount < TH && pix.colcount < TW) begin
        out_img[pix.rowcount][pix.colcount] = pix.dout;
        seen[pix.rowcount][pix.colcount]++;
      end else begin
        oob++;
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [7:0] img [0:TH-1][0:TW-1];
  int acc66_cyc = 0;

  task automatic fill(input logic [7:0] v);
    for (int r = 0; r < TH; r++)
      for (int c = 0; c < TW; c++)
        img[r][c] = v;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      pix.valid = 1'b0;
    end
  endtask

  task automatic start_frame();
    frame_tag++;
    @(negedge clock);
    @(negedge clock);
  endtask

  task automatic drive_frame(input int hblank, input int vlines, input int npix);
    int k = 0;
    for (int r = 0; r < TH; r++) begin
      for (int c = 0; c < TW; c++) begin
        if (k == npix) return;
        @(negedge clock);
        pix.din = img[r][c];
        pix.valid = 1'b1;
        if (r == 6 && c == 6) acc66_cyc = cyc + 1;
        k++;
      end
      idle(hblank);
    end
    idle(vlines * (TW + hblank) + 4);
  endtask

  task automatic check_shape(input string tag);
    int bad_cov = 0;
    for (int r = 0; r < TH; r++)
      for (int c = 0; c < TW; c++)
        if (seen[r][c] != ((r >= 3 && r <= TH - 4 && c >= 3 && c <= TW - 4) ? 1 : 0))
          bad_cov++;
    check({tag, " pulses"}, pulses, EXP_PULSES);
    check({tag, " coverage"}, bad_cov, 0);
    check({tag, " out_of_range"}, oob, 0);
    check({tag, " first_row"}, first_row, 3);
    check({tag, " first_col"}, first_col, 3);
    check({tag, " last_row"}, last_row, TH - 4);
    check({tag, " last_col"}, last_col, TW - 4);
    check({tag, " latency"}, first_cyc - acc66_cyc, 2);
  endtask

  task automatic run_centre(input string tag, input logic [7:0] exp);
    start_frame();
    drive_frame(2, 1, NPIX);
    check({tag, " pulses"}, pulses, EXP_PULSES);
    check({tag, " dout(5,6)"}, out_img[5][6], exp);
  endtask

  initial begin
    reset = 1'b1;
    pix.din = 8'h55;
    pix.valid = 1'b1;
    repeat (3) begin
      @(posedge clock);
      #1;
      check("reset validout", pix.validout, 0);
      check("reset dout", pix.dout, 0);
      check("reset rowcount", pix.rowcount, 0);
      check("reset colcount", pix.colcount, 0);
    end
    @(negedge clock);
    reset = 1'b0;
    pix.valid = 1'b0;
    idle(3);

    // Uniform frames: every result is the background, and wrap restarts at (3,3).
    fill(8'h90);
    for (int f = 0; f < 4; f++) begin
      int bad = 0;
      start_frame();
      drive_frame(4, 2, NPIX);
      check_shape($sformatf("uniform f%0d", f));
      for (int r = 3; r <= TH - 4; r++)
        for (int c = 3; c <= TW - 4; c++)
          if (out_img[r][c] !== 8'h90) bad++;
      check($sformatf("uniform f%0d dout", f), bad, 0);
    end

    // Dark spot at (6,7) on 0x80.
    fill(8'h80);
    img[6][7] = 8'h10;
    start_frame();
    drive_frame(2, 1, NPIX);
    check_shape("spot");
    check("spot centre", out_img[6][7], 8'hFF);
    check("spot above S-only", out_img[3][7], 8'h80);
    check("spot left E-only", out_img[6][4], 8'h80);
    check("spot right W-only", out_img[6][10], 8'h80);
    check("spot background", out_img[5][5], 8'h80);

    // Threshold edges around centre (5,6).
    fill(8'h64); img[5][6] = 8'h50; run_centre("thr diff20", 8'hFF);
    fill(8'h63); img[5][6] = 8'h50; run_centre("thr diff19", 8'h50);
    fill(8'hFF); img[5][6] = 8'hF0; run_centre("thr no-wrap", 8'hF0);

    // 3-of-4 and mixed cases: N=(2,6) S=(8,6) W=(5,3) E=(5,9).
    fill(8'h50); img[2][6] = 8'h70; img[8][6] = 8'h70; img[5][9] = 8'h70;
    run_centre("three bright", EXP_THREE);
    fill(8'h50); img[2][6] = 8'h30; img[8][6] = 8'h30; img[5][9] = 8'h30;
    run_centre("three dark", EXP_THREE);
    fill(8'h50); img[2][6] = 8'h70; img[8][6] = 8'h70; img[5][3] = 8'h30; img[5][9] = 8'h30;
    run_centre("mixed 2+2", 8'h50);
    fill(8'h50); img[2][6] = 8'h70; img[8][6] = 8'h70; img[5][3] = 8'h70; img[5][9] = 8'h70;
    run_centre("four bright", 8'hFF);

    // Reset mid-frame at row 8 with results in flight.
    fill(8'h20);
    start_frame();
    drive_frame(0, 0, 8 * TW + 9);
    @(negedge clock);
    reset = 1'b1;
    pix.valid = 1'b1;
    @(posedge clock);
    #1;
    check("midreset validout at edge", pix.validout, 0);
    @(negedge clock);
    reset = 1'b0;
    pix.valid = 1'b0;
    start_frame();
    idle(4);
    check("midreset silent", pulses, 0);
    fill(8'h80);
    img[6][7] = 8'h10;
    drive_frame(1, 1, NPIX);
    check_shape("midreset");
    check("midreset first dout", out_img[3][3], 8'h80);
    check("midreset spot", out_img[6][7], 8'hFF);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/check4.md
# check4

Streaming FAST-style 4-point corner pre-test for the feature-detection pipeline. Consumes raster-order 8-bit grayscale pixels of an 800×600 frame and compares each interior pixel with its four compass neighbours at radius 3. For every pixel with a complete 7×7 neighbourhood it emits a result, tagged with that pixel's row/column. Sits between the pixel source (DVI/camera input) and the full-circle FAST stage.

## Interface
- WIDTH, 800: active pixels per line.
- HEIGHT, 600: active lines per frame.
- THRESHOLD, 20: brightness margin, unsigned 8-bit.
- Ports (one clock; reset is synchronous and active-high):
- clock  in  1  sole clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- din  in  8  input pixel.
- valid  in  1  din is an active pixel this cycle; accepted unconditionally, no backpressure.
- dout  out  8  result pixel.
- validout  out  1  dout/rowcount/colcount are valid this cycle.
- rowcount  out  10  row of the centre pixel dout refers to.
- colcount  out  10  column of the centre pixel dout refers to.

## Operation
- Input position counters in_col/in_row start at 0.
  - Each accepted pixel (valid=1) increments in_col.
  - At WIDTH-1, in_col wraps to 0 and in_row increments.
  - At in_row HEIGHT-1 with in_col WIDTH-1, both wrap to 0 (next frame).
  - Cycles with valid=0 change nothing.
- Six cascaded line buffers (WIDTH×8 each) hold the previous six lines. A 7-column shift window is advanced only on accepted pixels.
- When a pixel is accepted at input position (r,c) with r≥6 and c≥6:
  - Centre C = (r-3,c-3).
  - N = (r-6,c-3), S = (r,c-3), W = (r-3,c-6), E = (r-3,c).
- Compare each compass pixel p against C in 9-bit unsigned arithmetic, so no wrap:
  - brighter if p ≥ C+THRESHOLD.
  - darker if p+THRESHOLD ≤ C.
- Candidate if ≥3 of 4 are brighter, or ≥3 of 4 are darker. Brighter and darker counts are never mixed.
- Outputs:
  - dout = 8'hFF for a candidate, otherwise C's value.
  - rowcount = r-3, colcount = c-3.
  - validout = 1.
- Border pixels (row <3, row >HEIGHT-4, col <3, col >WIDTH-4) never produce output.
  - Per frame: (HEIGHT-6)×(WIDTH-6) = 594×794 = 471,636 validout pulses.
- Reset values: dout=0, validout=0, rowcount=0, colcount=0, counters=0, pipeline valid flags=0.
  - Line-buffer contents are not reset; the r≥6/c≥6 gating hides stale data.
- Reset mid-frame: the next accepted pixel is treated as (0,0) of a new frame. No output until 6 lines + 7 pixels are re-accepted.

## Timing
- 2-stage pipeline, fixed latency 2 cycles.
  - Pixel accepted at edge N: window registered at N+1, compare/output registered at N+2.
  - validout is high during the cycle after edge N+2 for exactly one cycle per qualifying pixel.
- The pipeline advances every cycle regardless of valid. Gaps in valid insert equal gaps in validout; there is no stall or flush.
- Back-to-back valid gives back-to-back validout.
- Line/frame blanking needs no special handling; wrap is driven purely by accepted-pixel counts.
- Reset asserted on an edge clears validout at that edge. In-flight results are discarded.
- Throughput: 1 pixel/cycle.

## Configuration
- CHECK4_STRICT_EN defined: a candidate requires all 4 compass pixels brighter, or all 4 darker.
- CHECK4_STRICT_EN undefined (default): ≥3 of 4 is enough.
- The macro changes nothing else: latency, ports and counts are unaffected.

## Structure
- Package check4_pkg:
  - pixel_t (8-bit), coord_t (10-bit).
  - RADIUS=3, default WIDTH/HEIGHT/THRESHOLD.
  - Candidate marker constant 8'hFF.
- Sub-module check4_line_buffer: a WIDTH-deep × 8 single-port delay line, write-then-shift on valid. Six instances are chained. The compare logic stays in check4.

## Test plan
- Reset: hold reset 3 cycles with valid=1 -> validout=0, dout=0, rowcount=0, colcount=0 throughout.
- Uniform frame din=8'h90, 800 valid + 100 idle cycles per line, 100 idle lines, 4 frames:
  - 471,636 pulses per frame, all dout=8'h90.
  - First result rowcount=3, colcount=3, 2 cycles after accepting (6,6).
  - Last result (596,796).
  - Next frame's first result is again (3,3).
- Dark spot, background 8'h80 with (100,100)=8'h10:
  - Output at (100,100) is dout=8'hFF.
  - Output at (97,100) is 8'h80: only S is darker, so not a candidate.
- Threshold edge, C=8'h50:
  - N,S,E,W=8'h64 (diff 20) -> 8'hFF.
  - All at 8'h63 -> 8'h50.
  - C=8'hF0 with compass 8'hFF -> not a candidate (9-bit compare, no overflow).
- 3-vs-4: N,S,E bright and W equal -> 8'hFF by default, C value with CHECK4_STRICT_EN. Mixed 2 bright + 2 dark -> C value.
- Reset mid-frame at row 300:
  - Output is silent until 6 full lines + 7 pixels are accepted.
  - The first result is then (3,3), with correct data.
